// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Two-requester access controller for the core's word-addressed data memory
// (MEM_WORDS x 32 bit, asynchronous read, synchronous word write). Port C is
// the core load/store unit, port D is the debug/DMA port. Byte and halfword
// requests become word accesses: sub-word stores do a same-cycle
// read-modify-write, and sub-word loads are sign- or zero-extended. Every
// accepted request produces exactly one registered response on its own port.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   {c,d}_req_valid/ready   request handshake (ready only ever high in IDLE)
//   {c,d}_req_we            1 = store, 0 = load
//   {c,d}_req_size          00 byte, 01 half, 10 word, 11 illegal
//   {c,d}_req_unsigned      zero-extend loads when 1
//   {c,d}_req_addr          byte address
//   {c,d}_req_wdata         store data, right-aligned
//   {c,d}_rsp_valid/ready   response handshake
//   {c,d}_rsp_rdata         extended load data, 0 for stores and errors
//   {c,d}_rsp_err           misaligned, out-of-range or illegal size
//   mem_addr/we/wd          word-aligned address, write enable, merged word
//   mem_rd                  asynchronous read word from memory
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req_valid,
    output logic        c_req_ready,
    input  logic        c_req_we,
    input  logic [1:0]  c_req_size,
    input  logic        c_req_unsigned,
    input  logic [31:0] c_req_addr,
    input  logic [31:0] c_req_wdata,
    output logic        c_rsp_valid,
    input  logic        c_rsp_ready,
    output logic [31:0] c_rsp_rdata,
    output logic        c_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [1:0]  d_req_size,
    input  logic        d_req_unsigned,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {PORT_C = 1'b0, PORT_D = 1'b1} port_t;

    state_t      state, state_next;
    port_t       last_grant, lat_port;
    logic        lat_we, lat_unsigned;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic        grant_c, grant_d;
    logic        access_err;
    logic [4:0]  shamt;
    logic [31:0] lane, load_data, mask, merged;
    logic        rsp_ready_sel;

    // Round-robin arbitration: on a tie the port opposite the last grant wins.
    // Ready is held low while reset is asserted even though the state already
    // reads IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (!reset && state == IDLE) begin
            if (c_req_valid && d_req_valid) begin
                grant_c = (last_grant == PORT_D);
                grant_d = (last_grant == PORT_C);
            end else begin
                grant_c = c_req_valid;
                grant_d = d_req_valid;
            end
        end
    end

    assign c_req_ready = grant_c;
    assign d_req_ready = grant_d;

    // Access datapath, evaluated against the latched request.
    always_comb begin
        shamt      = {lat_addr[1:0], 3'b000};
        access_err = (lat_size == 2'b11)
                   || (lat_size == 2'b01 && lat_addr[0])
                   || (lat_size == 2'b10 && lat_addr[1:0] != 2'b00)
                   || (lat_addr >= ADDR_LIMIT);
        lane = mem_rd >> shamt;
        case (lat_size)
            2'b00:   load_data = {{24{~lat_unsigned & lane[7]}}, lane[7:0]};
            2'b01:   load_data = {{16{~lat_unsigned & lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
        case (lat_size)
            2'b00:   mask = 32'h0000_00FF << shamt;
            2'b01:   mask = 32'h0000_FFFF << shamt;
            default: mask = 32'hFFFF_FFFF;
        endcase
        merged = (mem_rd & ~mask) | ((lat_wdata << shamt) & mask);
    end

    assign rsp_ready_sel = (lat_port == PORT_C) ? c_rsp_ready : d_rsp_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state and memory-side outputs.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wd     = 32'h0;
        case (state)
            IDLE:   if (grant_c || grant_d) state_next = ACCESS;
            ACCESS: begin
                mem_addr = {lat_addr[31:2], 2'b00};
                if (lat_we && !access_err) begin
                    mem_we = 1'b1;
                    mem_wd = merged;
                end
                state_next = RESP;
            end
            RESP:    if (rsp_ready_sel) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, grant pointer and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant   <= PORT_D;
            lat_port     <= PORT_C;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (grant_c || grant_d) begin
                last_grant   <= grant_c ? PORT_C : PORT_D;
                lat_port     <= grant_c ? PORT_C : PORT_D;
                lat_we       <= grant_c ? c_req_we       : d_req_we;
                lat_size     <= grant_c ? c_req_size     : d_req_size;
                lat_unsigned <= grant_c ? c_req_unsigned : d_req_unsigned;
                lat_addr     <= grant_c ? c_req_addr     : d_req_addr;
                lat_wdata    <= grant_c ? c_req_wdata    : d_req_wdata;
            end
            if (state == ACCESS) begin
                rsp_err_q  <= access_err;
                rsp_data_q <= (!access_err && !lat_we) ? load_data : 32'h0;
            end
        end
    end

    // Responses appear only on the latched port, and only while in RESP.
    assign c_rsp_valid = (state == RESP) && (lat_port == PORT_C);
    assign d_rsp_valid = (state == RESP) && (lat_port == PORT_D);
    assign c_rsp_rdata = c_rsp_valid ? rsp_data_q : 32'h0;
    assign d_rsp_rdata = d_rsp_valid ? rsp_data_q : 32'h0;
    assign c_rsp_err   = c_rsp_valid & rsp_err_q;
    assign d_rsp_err   = d_rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Self-checking bench for dmem_access_ctrl. Holds a data memory attached to
// the controller's memory port and a byte-addressed reference model that
// applies the load/store/error rules directly.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int MEM_WORDS = 1024;
    localparam int MEM_BYTES = 4 * MEM_WORDS;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req_valid, c_req_ready, c_req_we, c_req_unsigned;
    logic [1:0]  c_req_size;
    logic [31:0] c_req_addr, c_req_wdata;
    logic        c_rsp_valid, c_rsp_ready, c_rsp_err;
    logic [31:0] c_rsp_rdata;
    logic        d_req_valid, d_req_ready, d_req_we, d_req_unsigned;
    logic [1:0]  d_req_size;
    logic [31:0] d_req_addr, d_req_wdata;
    logic        d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_rsp_rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] dmem [MEM_WORDS];
    logic [7:0]  ref_bytes [MEM_BYTES];
    bit          last_grant;   // 0 = C, 1 = D

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
        .c_req_size(c_req_size), .c_req_unsigned(c_req_unsigned),
        .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
        .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready),
        .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Data memory: asynchronous read, synchronous word write.
    assign mem_rd = (mem_addr < 32'(MEM_BYTES)) ? dmem[mem_addr[11:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'(MEM_BYTES)) dmem[mem_addr[11:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int a = int'(addr) & ~3;
        return {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
    endfunction

    // Reference semantics on a byte array: n = 2**size bytes, little-endian.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
        int n = 1 << size;
        err   = (size == 2'b11) || (addr % n != 0) || (addr >= 32'(MEM_BYTES));
        rdata = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rdata |= 32'(ref_bytes[int'(addr) + i]) << (8 * i);
                if (!uns && n < 4 && rdata[8*n-1]) rdata |= 32'hFFFF_FFFF << (8 * n);
            end
        end
    endtask

    task automatic drive_req(input bit port, input logic v, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            c_req_valid = v; c_req_we = we; c_req_size = size;
            c_req_unsigned = uns; c_req_addr = addr; c_req_wdata = wdata;
        end else begin
            d_req_valid = v; d_req_we = we; d_req_size = size;
            d_req_unsigned = uns; d_req_addr = addr; d_req_wdata = wdata;
        end
    endtask

    // One uncontended transaction from IDLE with rsp_ready already high.
    task automatic txn(input bit port, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd, exp_wd;
        logic        exp_err;
        ref_access(we, size, uns, addr, wdata, exp_rd, exp_err);
        exp_wd = exp_err ? 32'h0 : ref_word(addr);
        @(posedge clk) #1;
        drive_req(port, 1'b1, we, size, uns, addr, wdata);
        @(negedge clk);
        check("req_ready", port ? d_req_ready : c_req_ready, 32'd1);
        check("other_ready", port ? c_req_ready : d_req_ready, 32'd0);
        last_grant = port;
        @(posedge clk) #1;
        drive_req(port, 1'b0, we, size, uns, addr, wdata);
        @(negedge clk);
        check("access_rsp_valid", port ? d_rsp_valid : c_rsp_valid, 32'd0);
        check("mem_we", mem_we, 32'(we && !exp_err));
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        if (we && !exp_err) check("mem_wd", mem_wd, exp_wd);
        @(negedge clk);
        check("rsp_valid", port ? d_rsp_valid : c_rsp_valid, 32'd1);
        check("other_rsp_valid", port ? c_rsp_valid : d_rsp_valid, 32'd0);
        rd = port ? d_rsp_rdata : c_rsp_rdata;
        er = port ? d_rsp_err : c_rsp_err;
        check("rsp_rdata", rd, exp_rd);
        check("rsp_err", 32'(er), 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, v, exp_c, exp_d;
        logic        er, e_c, e_d;
        bit          winner;
        int          bad;

        for (int w = 0; w < MEM_WORDS; w++) begin
            v = $urandom;
            dmem[w] <= v;
            for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = v[8*b +: 8];
        end
        reset = 1'b1;
        c_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        drive_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        last_grant = 1'b1;

        // Reset values, with both requests asserted.
        @(negedge clk);
        check("rst_c_ready", c_req_ready, 0);
        check("rst_d_ready", d_req_ready, 0);
        check("rst_c_rsp_valid", c_rsp_valid, 0);
        check("rst_d_rsp_valid", d_rsp_valid, 0);
        check("rst_c_rdata", c_rsp_rdata, 0);
        check("rst_d_err", d_rsp_err, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wd", mem_wd, 0);
        c_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Word round-trip.
        txn(0, 1, 2'b10, 0, 32'h100, 32'hDEAD_BEEF, rd, er);
        txn(0, 0, 2'b10, 0, 32'h100, 32'h0, rd, er);
        check("word_roundtrip", rd, 32'hDEAD_BEEF);

        // Sub-word read-modify-write.
        txn(0, 1, 2'b10, 0, 32'h10, 32'h1122_3344, rd, er);
        txn(0, 1, 2'b00, 0, 32'h11, 32'h0000_00AA, rd, er);
        txn(0, 1, 2'b01, 0, 32'h12, 32'h0000_BEEF, rd, er);
        txn(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er);
        check("rmw_word", rd, 32'hBEEF_AA44);

        // Load extension.
        txn(0, 1, 2'b10, 0, 32'h20, 32'h0000_80F0, rd, er);
        txn(0, 0, 2'b00, 0, 32'h20, 32'h0, rd, er);
        check("ld_byte_signed", rd, 32'hFFFF_FFF0);
        txn(0, 0, 2'b00, 1, 32'h20, 32'h0, rd, er);
        check("ld_byte_unsigned", rd, 32'h0000_00F0);
        txn(0, 0, 2'b01, 0, 32'h20, 32'h0, rd, er);
        check("ld_half_signed", rd, 32'hFFFF_80F0);

        // Error cases: no write, zero data, memory untouched.
        txn(0, 1, 2'b01, 0, 32'h3, 32'h1234, rd, er);
        check("err_half_store", 32'(er), 1);
        check("err_half_mem", dmem[0], ref_word(32'h0));
        txn(1, 0, 2'b10, 0, 32'h6, 32'h0, rd, er);
        check("err_word_load", 32'(er), 1);
        txn(0, 1, 2'b00, 0, 32'h1000, 32'h77, rd, er);
        check("err_oor_store", 32'(er), 1);
        txn(1, 1, 2'b11, 0, 32'h8, 32'hCAFE_F00D, rd, er);
        check("err_size11", 32'(er), 1);
        check("err_size11_mem", dmem[2], ref_word(32'h8));

        // Last legal byte address.
        txn(1, 1, 2'b00, 0, 32'hFFF, 32'h1234_56A5, rd, er);
        check("edge_store_err", 32'(er), 0);
        txn(0, 0, 2'b00, 1, 32'hFFF, 32'h0, rd, er);
        check("edge_load", rd, 32'h0000_00A5);

        // D response stalled 5 cycles while C waits; pointer is C so D wins.
        txn(0, 0, 2'b10, 0, 32'h100, 32'h0, rd, er);
        ref_access(0, 2'b10, 0, 32'h100, 32'h0, exp_c, e_c);
        ref_access(0, 2'b10, 0, 32'h10, 32'h0, exp_d, e_d);
        @(posedge clk) #1;
        d_rsp_ready = 1'b0;
        drive_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        drive_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("stall_d_ready", d_req_ready, 1);
        check("stall_c_ready0", c_req_ready, 0);
        last_grant = 1'b1;
        @(posedge clk) #1;
        d_req_valid = 1'b0;
        @(negedge clk);
        check("stall_access_c_ready", c_req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_d_rsp_valid", d_rsp_valid, 1);
            check("stall_d_rdata", d_rsp_rdata, exp_d);
            check("stall_d_err", d_rsp_err, 0);
            check("stall_c_ready", c_req_ready, 0);
            check("stall_c_rsp_valid", c_rsp_valid, 0);
        end
        @(posedge clk) #1;
        d_rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", d_rsp_valid, 1);
        check("stall_release_c_ready", c_req_ready, 0);
        @(negedge clk);
        check("stall_c_granted", c_req_ready, 1);
        last_grant = 1'b0;
        @(posedge clk) #1;
        c_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stall_c_rsp_valid_end", c_rsp_valid, 1);
        check("stall_c_rdata", c_rsp_rdata, exp_c);

        // Reset during the ACCESS cycle of a store.
        @(posedge clk) #1;
        drive_req(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h55);
        @(negedge clk);
        check("rstmid_c_ready", c_req_ready, 1);
        @(posedge clk) #1;
        c_req_valid = 1'b0;
        #2;
        check("rstmid_mem_we_before", mem_we, 1);
        check("rstmid_mem_wd_before", mem_wd, 32'h55);
        reset = 1'b1;
        #1;
        check("rstmid_mem_we", mem_we, 0);
        check("rstmid_mem_addr", mem_addr, 0);
        check("rstmid_mem_wd", mem_wd, 0);
        check("rstmid_c_rsp_valid", c_rsp_valid, 0);
        check("rstmid_d_rsp_valid", d_rsp_valid, 0);
        check("rstmid_c_rdata", c_rsp_rdata, 0);
        c_req_valid = 1'b1;
        d_req_valid = 1'b1;
        #1;
        check("rstmid_c_ready", c_req_ready, 0);
        check("rstmid_d_ready", d_req_ready, 0);
        @(posedge clk) #1;
        check("rstmid_mem_unchanged", dmem[16], ref_word(32'h40));
        c_req_valid = 1'b0;
        d_req_valid = 1'b0;
        last_grant = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Both ports valid continuously: grants alternate, C first.
        ref_access(0, 2'b10, 0, 32'h100, 32'h0, exp_c, e_c);
        ref_access(0, 2'b01, 1, 32'h20, 32'h0, exp_d, e_d);
        @(posedge clk) #1;
        drive_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        drive_req(1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        winner = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                winner = !last_grant;
                check("arb_c_ready", c_req_ready, 32'(!winner));
                check("arb_d_ready", d_req_ready, 32'(winner));
                last_grant = winner;
            end else begin
                check("arb_busy_c_ready", c_req_ready, 0);
                check("arb_busy_d_ready", d_req_ready, 0);
            end
            if (k % 3 == 2) begin
                check("arb_c_rsp_valid", c_rsp_valid, 32'(!winner));
                check("arb_d_rsp_valid", d_rsp_valid, 32'(winner));
                check("arb_rdata", winner ? d_rsp_rdata : c_rsp_rdata, winner ? exp_d : exp_c);
            end
        end
        @(posedge clk) #1;
        c_req_valid = 1'b0;
        d_req_valid = 1'b0;

        // Randomised traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            int          r;
            logic [1:0]  size;
            logic [31:0] addr;
            r    = $urandom_range(0, 9);
            size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4088, 4100))
                                                : 32'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), size,
                1'($urandom_range(0, 1)), addr, $urandom, rd, er);
        end

        // Whole memory against the reference.
        bad = 0;
        for (int w = 0; w < MEM_WORDS; w++)
            if (dmem[w] !== ref_word(32'(4 * w))) bad++;
        check("final_mem_bad_words", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
